md_sched: RTL and testbench

Multi-cycle multiply/divide scheduler for the pipelined MIPS core. Accepts mult/multu/div/divu/mthi/mtlo from the E stage, holds the HI/LO registers, and runs each arithmetic operation for a fixed number of cycles. While it runs, it raises a stall request so the hazard logic freezes any later instruction that touches HI/LO. MDOut is the HI/LO read source for mfhi/mflo and feeds the E-stage result path ahead of the writeback select.

---
 rtl/md_sched.sv | 148 ++++++++++++++
 tb/tb_md_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// HI/LO multiply/divide unit: latches the result up front, then holds Busy
// for a fixed cycle count before committing it to HI/LO.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoSel,
    input  logic        MDUse,
    output logic [31:0] MDOut,
    output logic        Busy,
    output logic        Stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   res_hi_q, res_hi_d;
    logic [31:0]   res_lo_q, res_lo_d;
    logic          wr_en_q, wr_en_d;

    logic          start_arith;
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   div_b;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   q_s;
    logic [31:0]   r_s;
    logic [31:0]   q_u;
    logic [31:0]   r_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 on B==0 so the dividers never see zero;
    // the result is dropped anyway because wr_en stays low.
    assign div_b = (B == 32'd0) ? 32'd1 : B;
    assign a_mag = A[31] ? (32'd0 - A) : A;
    assign b_mag = div_b[31] ? (32'd0 - div_b) : div_b;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (A[31] ^ div_b[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = A[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = A / div_b;
    assign r_u   = A % div_b;

    assign start_arith = Start & (MDOp >= 3'd1) & (MDOp <= 3'd4);
    assign Busy  = (state_q == RUN);
    assign Stall = ~reset & MDUse & (Busy | start_arith);
    assign MDOut = HiLoSel ? hi_q : lo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_en_d  = wr_en_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    unique case (MDOp)
                        3'b001: begin
                            res_hi_d = prod_s[63:32];
                            res_lo_d = prod_s[31:0];
                            wr_en_d  = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = RUN;
                        end
                        3'b010: begin
                            res_hi_d = prod_u[63:32];
                            res_lo_d = prod_u[31:0];
                            wr_en_d  = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = RUN;
                        end
                        3'b011: begin
                            res_hi_d = r_s;
                            res_lo_d = q_s;
                            wr_en_d  = (B != 32'd0);
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = RUN;
                        end
                        3'b100: begin
                            res_hi_d = r_u;
                            res_lo_d = q_u;
                            wr_en_d  = (B != 32'd0);
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = RUN;
                        end
                        3'b101: hi_d = A;
                        3'b110: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    if (wr_en_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_en_q  <= wr_en_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed HI/LO scenarios followed by random traffic,
// all compared cycle by cycle against a high-level arithmetic model.
module tb_md_sched;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoSel;
    logic        MDUse;
    logic [31:0] MDOut;
    logic        Busy;
    logic        Stall;

    always #5 clk = ~clk;

    md_sched #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .HiLoSel (HiLoSel),
        .MDUse   (MDUse),
        .MDOut   (MDOut),
        .Busy    (Busy),
        .Stall   (Stall)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: architectural HI/LO, pending result, cycles left
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_wr;
    int          m_left;
    int          busy_cnt;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model_calc(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p_wr = 1'b1;
        case (op)
            3'd1: begin
                sp = sa * sb;
                v = sp;
                p_hi = v[63:32];
                p_lo = v[31:0];
            end
            3'd2: begin
                up = ua * ub;
                v = up;
                p_hi = v[63:32];
                p_lo = v[31:0];
            end
            3'd3: begin
                if (b == 0) p_wr = 1'b0;
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p_lo = sq[31:0];
                    p_hi = sr[31:0];
                end
            end
            default: begin
                if (b == 0) p_wr = 1'b0;
                else begin
                    p_lo = 32'(ua / ub);
                    p_hi = 32'(ua % ub);
                end
            end
        endcase
    endfunction

    task automatic step(bit rst, bit st, logic [2:0] op,
                        logic [31:0] a, logic [31:0] b, bit mu);
        bit arith, e_busy, e_stall;
        reset = rst;
        Start = st;
        MDOp  = op;
        A     = a;
        B     = b;
        MDUse = mu;
        HiLoSel = 1'($urandom_range(0, 1));
        #4;
        arith   = st && op >= 3'd1 && op <= 3'd4;
        e_busy  = m_left > 0;
        e_stall = !rst && mu && (e_busy || arith);
        check("busy", 32'(Busy), 32'(e_busy));
        check("stall", 32'(Stall), 32'(e_stall));
        check("mdout", MDOut, HiLoSel ? m_hi : m_lo);
        HiLoSel = ~HiLoSel;
        #1;
        check("mdout_sel", MDOut, HiLoSel ? m_hi : m_lo);
        if (Busy === 1'b1) busy_cnt++;
        @(posedge clk);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_wr = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st) begin
            if (arith) begin
                model_calc(op, a, b);
                m_left = (op <= 3'd2) ? NM : ND;
            end else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
        end
        #1;
    endtask

    task automatic idle(int n, bit mu);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 32'd0, 32'd0, mu);
    endtask

    task automatic expect_hilo(string tag, logic [31:0] hi, logic [31:0] lo);
        Start = 0;
        reset = 0;
        MDUse = 0;
        HiLoSel = 1;
        #1;
        check({tag, "_hi"}, MDOut, hi);
        HiLoSel = 0;
        #1;
        check({tag, "_lo"}, MDOut, lo);
    endtask

    initial begin
        reset = 1; Start = 0; MDOp = 0; A = 0; B = 0; HiLoSel = 0; MDUse = 0;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0; m_left = 0;
        busy_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 1, 3'd1, 32'd3, 32'd3, 1);
        expect_hilo("reset", 32'd0, 32'd0);

        busy_cnt = 0;
        step(0, 1, 3'd1, 32'hFFFF_FFFD, 32'd7, 1);
        idle(1, 1);
        step(0, 1, 3'd5, 32'h0000_DEAD, 32'd0, 1);
        idle(4, 1);
        check("mult_busy_len", 32'(busy_cnt), 32'd5);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        step(0, 1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle(5, 0);
        expect_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        busy_cnt = 0;
        step(0, 1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1);
        idle(11, 1);
        check("div_busy_len", 32'(busy_cnt), 32'd10);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        step(0, 1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle(10, 0);
        expect_hilo("div_ovf", 32'd0, 32'h8000_0000);

        step(0, 1, 3'd5, 32'h1234_5678, 32'd0, 1);
        expect_hilo("mthi", 32'h1234_5678, 32'h8000_0000);
        step(0, 1, 3'd6, 32'h9ABC_DEF0, 32'd0, 1);
        expect_hilo("mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

        busy_cnt = 0;
        step(0, 1, 3'd4, 32'd5, 32'd0, 1);
        idle(11, 0);
        check("divz_busy_len", 32'(busy_cnt), 32'd10);
        expect_hilo("divz", 32'h1234_5678, 32'h9ABC_DEF0);

        step(0, 1, 3'd3, 32'd100, 32'd7, 1);
        idle(3, 1);
        step(1, 0, 3'd0, 32'd0, 32'd0, 1);
        expect_hilo("mid_reset", 32'd0, 32'd0);
        busy_cnt = 0;
        step(0, 1, 3'd1, 32'd3, 32'd4, 1);
        idle(5, 1);
        check("post_rst_busy", 32'(busy_cnt), 32'd5);
        expect_hilo("post_rst", 32'd0, 32'd12);

        // back-to-back: second start lands in the first non-busy cycle
        step(0, 1, 3'd2, 32'd6, 32'd7, 1);
        idle(5, 1);
        step(0, 1, 3'd4, 32'd100, 32'd9, 1);
        idle(10, 1);
        expect_hilo("b2b", 32'd1, 32'd11);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                 3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
